read_ram_unload: RTL and testbench

READ_RAM_UNLOAD -- requirements
Module: read_ram_unload

---
 rtl/read_ram_unload.sv | 207 ++++++++++++++++++++
 tb/tb_read_ram_unload.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/read_ram_unload.sv
// read_ram_unload: streams a page out of the page RAM once a page read has landed in it.
// The two validity-flag bytes come first (FLAG_ADDR, FLAG_ADDR+1), then data bytes 0..PAGE_BYTES-1.
// A flag byte equal to INVALID_MARK marks its half of the page as uncorrectable. With mask_en
// (sampled at start), data bytes in that half are replaced by 8'h00.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle pulse that begins an unload (ignored while busy)
//   mask_en          zero out data bytes of invalid halves
//   ram_en/ram_addr  registered RAM read request; ram_dataout returns one cycle later
//   out_data/out_valid/out_ready   byte stream, a beat is out_valid & out_ready
//   busy, done       unload in progress / one-cycle completion pulse
//   half_bad         bit0 = lower-half flag invalid, bit1 = upper-half flag invalid
module read_ram_unload #(
    parameter int unsigned PAGE_BYTES   = 8192,
    parameter int unsigned FLAG_ADDR    = 8192,
    parameter logic [7:0]  INVALID_MARK = 8'h55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mask_en,
    output logic        ram_en,
    output logic [14:0] ram_addr,
    input  logic [7:0]  ram_dataout,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  half_bad
);
    localparam int unsigned AW    = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
    // What a read in flight will return: lower/upper-half data or one of the flag bytes.
    typedef enum logic [1:0] {TAG_LO, TAG_HI, TAG_F0, TAG_F1} tag_t;

    state_t          state_q, state_d;
    logic            ram_en_q, ram_en_d;
    logic [14:0]     ram_addr_q, ram_addr_d;
    tag_t            tag_q, tag_d;
    logic            rvalid_q, rvalid_d;
    tag_t            rtag_q, rtag_d;
    logic            flag1_q, flag1_d;
    logic [AW-1:0]   addr_cnt_q, addr_cnt_d;
    logic            mask_q, mask_d;
    logic [1:0]      half_bad_q, half_bad_d;
    logic [7:0]      fifo_q [DEPTH];
    logic [7:0]      fifo_d [DEPTH];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [CW-1:0]   occ;
    logic [CW-1:0]   wr_idx;
    logic            can_issue;
    logic            pop;
    logic            push;
    logic [7:0]      push_data;

    // Next-state, read issue, return handling and output buffer.
    // fifo_q[0] is the output register; the buffer shifts down on every accepted beat.
    always_comb begin
        state_d     = state_q;
        ram_en_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        tag_d       = tag_q;
        flag1_d     = flag1_q;
        addr_cnt_d  = addr_cnt_q;
        mask_d      = mask_q;
        half_bad_d  = half_bad_q;
        done_d      = 1'b0;
        rvalid_d    = ram_en_q;
        rtag_d      = tag_q;
        fifo_d      = fifo_q;

        // Credits: buffered bytes plus reads still travelling through the RAM pipeline.
        occ       = cnt_q + CW'(ram_en_q) + CW'(rvalid_q);
        can_issue = (occ < CW'(DEPTH));

        // Return path; flags always return before any data, so masking sees settled flags.
        push      = rvalid_q;
        push_data = ram_dataout;
        if (rvalid_q && (rtag_q == TAG_F0) && (ram_dataout == INVALID_MARK)) begin
            half_bad_d[0] = 1'b1;
        end
        if (rvalid_q && (rtag_q == TAG_F1) && (ram_dataout == INVALID_MARK)) begin
            half_bad_d[1] = 1'b1;
        end
        if ((rtag_q == TAG_LO) || (rtag_q == TAG_HI)) begin
            if (mask_q && half_bad_q[rtag_q == TAG_HI]) begin
                push_data = 8'h00;
            end
        end

        pop = out_valid_q && out_ready;
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
        end
        wr_idx = cnt_q - CW'(pop);
        if (push) begin
            fifo_d[wr_idx[1:0]] = push_data;
        end
        cnt_d       = cnt_q - CW'(pop) + CW'(push);
        out_valid_d = (cnt_d != '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    ram_en_d   = 1'b1;
                    ram_addr_d = 15'(FLAG_ADDR);
                    tag_d      = TAG_F0;
                    flag1_d    = 1'b1;
                    addr_cnt_d = '0;
                    mask_d     = mask_en;
                    half_bad_d = 2'b00;
                end
            end
            FETCH: begin
                if (can_issue) begin
                    ram_en_d = 1'b1;
                    if (flag1_q) begin
                        ram_addr_d = 15'(FLAG_ADDR + 1);
                        tag_d      = TAG_F1;
                        flag1_d    = 1'b0;
                    end else begin
                        ram_addr_d = 15'(addr_cnt_q);
                        tag_d      = (32'(addr_cnt_q) >= PAGE_BYTES / 2) ? TAG_HI : TAG_LO;
                        if (addr_cnt_q == AW'(PAGE_BYTES - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            addr_cnt_d = addr_cnt_q + AW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if ((cnt_d == '0) && !ram_en_q && !rvalid_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            tag_q       <= TAG_LO;
            rvalid_q    <= 1'b0;
            rtag_q      <= TAG_LO;
            flag1_q     <= 1'b0;
            addr_cnt_q  <= '0;
            mask_q      <= 1'b0;
            half_bad_q  <= 2'b00;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= 8'h00;
            end
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            tag_q       <= tag_d;
            rvalid_q    <= rvalid_d;
            rtag_q      <= rtag_d;
            flag1_q     <= flag1_d;
            addr_cnt_q  <= addr_cnt_d;
            mask_q      <= mask_d;
            half_bad_q  <= half_bad_d;
            fifo_q      <= fifo_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign out_data  = fifo_q[0];
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign half_bad  = half_bad_q;

endmodule

// File: tb/tb_read_ram_unload.sv
// Bench for read_ram_unload: a RAM model with one-cycle read latency, a randomized
// consumer, and an expected byte queue built directly from the page contents and flag rules.
module tb_read_ram_unload;
    localparam int unsigned PAGE_BYTES = 8192;
    localparam int unsigned FLAG_ADDR  = 8192;
    localparam int unsigned NBEATS     = PAGE_BYTES + 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mask_en;
    logic        ram_en;
    logic [14:0] ram_addr;
    logic [7:0]  ram_dataout;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [1:0]  half_bad;

    logic [7:0]  mem [0:NBEATS-1];
    logic [7:0]  exp_q [$];
    int          n_vec     = 0;
    int          n_err     = 0;
    int          beats     = 0;
    int          done_cnt  = 0;
    int          duty      = 100;
    bit          mon_en    = 0;
    bit          hold_pend = 0;
    logic [7:0]  hold_data = 8'h00;

    read_ram_unload #(
        .PAGE_BYTES  (PAGE_BYTES),
        .FLAG_ADDR   (FLAG_ADDR),
        .INVALID_MARK(8'h55)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mask_en    (mask_en),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_dataout(ram_dataout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .half_bad   (half_bad)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Page RAM: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dataout <= (32'(ram_addr) < NBEATS) ? mem[ram_addr] : 8'hEE;
        end
    end

    // Consumer: accepts with probability duty percent, redrawn every cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = (int'($urandom_range(99)) < duty);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Beat scoreboard and stall-stability monitor.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'(1));
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    check($sformatf("beat%0d", beats), 32'(out_data), 32'(exp_q.pop_front()));
                end
                beats++;
            end
            if (done) done_cnt++;
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
        end else begin
            hold_pend = 0;
        end
    end

    task automatic run(input logic [7:0] f0, input logic [7:0] f1, input logic m,
                       input int rdy_duty, input bit incr, input bit restart, input int abort_at);
        int cyc;
        int first_v;
        int limit;
        bit aborted;
        bit bad;
        for (int a = 0; a < int'(PAGE_BYTES); a++) begin
            mem[a] = incr ? 8'(a) : 8'($urandom);
        end
        mem[FLAG_ADDR]     = f0;
        mem[FLAG_ADDR + 1] = f1;
        exp_q.delete();
        exp_q.push_back(f0);
        exp_q.push_back(f1);
        for (int a = 0; a < int'(PAGE_BYTES); a++) begin
            bad = (a >= int'(PAGE_BYTES / 2)) ? (f1 == 8'h55) : (f0 == 8'h55);
            exp_q.push_back((m && bad) ? 8'h00 : mem[a]);
        end
        duty     = rdy_duty;
        beats    = 0;
        done_cnt = 0;
        limit    = (rdy_duty >= 100) ? int'(PAGE_BYTES) + 50 : 60000;

        @(posedge clk);
        #1 start = 1'b1;
        mask_en = m;
        @(posedge clk);
        #1 start = 1'b0;
        mask_en = ~m;
        check("first_rd_en", 32'(ram_en), 32'(1));
        check("first_rd_addr", 32'(ram_addr), 32'(FLAG_ADDR));
        check("busy_on", 32'(busy), 32'(1));
        check("half_bad_clr", 32'(half_bad), 32'(0));

        cyc     = 1;
        first_v = -1;
        aborted = 0;
        while (!done && cyc < limit) begin
            if (out_valid && first_v < 0) first_v = cyc;
            if (abort_at > 0 && beats >= abort_at) begin
                aborted = 1;
                break;
            end
            start = restart && (cyc == 50);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;

        if (aborted) begin
            rst = 1'b1;
            #2;
            check("rst_valid", 32'(out_valid), 32'(0));
            check("rst_data", 32'(out_data), 32'(0));
            check("rst_ram_en", 32'(ram_en), 32'(0));
            check("rst_ram_addr", 32'(ram_addr), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_done", 32'(done), 32'(0));
            check("rst_half_bad", 32'(half_bad), 32'(0));
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            check("abort_no_done", 32'(done_cnt), 32'(0));
            check("abort_idle", 32'(busy), 32'(0));
            check("abort_no_valid", 32'(out_valid), 32'(0));
            exp_q.delete();
            return;
        end

        check("done_seen", 32'(done), 32'(1));
        check("first_valid_lat", 32'(first_v >= 0 && first_v <= 3), 32'(1));
        if (rdy_duty >= 100) begin
            check("done_latency", 32'(cyc <= int'(PAGE_BYTES) + 6), 32'(1));
        end
        @(negedge clk);
        repeat (8) @(posedge clk);
        #1;
        check("beat_count", 32'(beats), 32'(NBEATS));
        check("exp_left", 32'(exp_q.size()), 32'(0));
        check("done_once", 32'(done_cnt), 32'(1));
        check("busy_off", 32'(busy), 32'(0));
        check("valid_off", 32'(out_valid), 32'(0));
        check("half_bad", 32'(half_bad), 32'({f1 == 8'h55, f0 == 8'h55}));
    endtask

    initial begin
        logic [7:0] rf0;
        logic [7:0] rf1;
        rst     = 1'b1;
        start   = 1'b0;
        mask_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'(0));
        check("reset_data", 32'(out_data), 32'(0));
        check("reset_ram_en", 32'(ram_en), 32'(0));
        check("reset_ram_addr", 32'(ram_addr), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_half_bad", 32'(half_bad), 32'(0));
        rst    = 1'b0;
        mon_en = 1;

        // Incrementing page, both halves valid, full-rate consumer.
        run(8'h00, 8'h00, 1'b1, 100, 1'b1, 1'b0, 0);
        // Lower half invalid and masked; a second start mid-unload must be ignored.
        run(8'h55, 8'h00, 1'b1, 100, 1'b0, 1'b1, 0);
        // Upper half invalid but masking off.
        run(8'h00, 8'h55, 1'b0, 100, 1'b0, 1'b0, 0);
        // Both halves invalid, masked, sparse consumer.
        run(8'h55, 8'h55, 1'b1, 30, 1'b0, 1'b0, 0);
        // Reset at beat 100, then a fresh unload with random flags.
        run(8'h55, 8'h00, 1'b1, 100, 1'b0, 1'b0, 100);
        rf0 = ($urandom_range(1) != 0) ? 8'h55 : 8'($urandom);
        rf1 = ($urandom_range(1) != 0) ? 8'h55 : 8'($urandom);
        run(rf0, rf1, 1'b1, 100, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
